chunked_serial_adder: RTL and testbench
=======================================

# chunked_serial_adder

Parametrised multi-cycle adder/subtractor: the generalised successor of the team's fixed 8-bit ripple-carry adder. It processes a WIDTH-bit operand pair DIGIT bits per clock through one DIGIT-bit ripple slice, carrying between chunks in a register. This trades latency for area. It sits between operand producers and result consumers on valid/ready handshakes, and reports carry-out and signed overflow alongside the sum.

## Interface
- WIDTH, 16, operand/result width; must be a positive multiple of DIGIT (elaboration error otherwise)
- DIGIT, 4, bits added per cycle; 1 ≤ DIGIT ≤ WIDTH; N = WIDTH/DIGIT chunk cycles per operation
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous and active-high
- in_valid  input  1  operand pair and mode are presented
- in_ready  output  1  block can accept an operation (high only in IDLE)
- a  input  WIDTH  operand A (unsigned or two's complement)
- b  input  WIDTH  operand B
- sub  input  1  0: A+B, 1: A−B (computed as A + ~B + 1)
- sum  output  WIDTH  result, registered
- cout  output  1  carry out of MSB (for sub: 1 = no borrow)
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB
- out_valid  output  1  result valid; held until accepted
- out_ready  input  1  consumer accepts result

## Operation
- FSM states: IDLE, RUN, DONE. Chunk index counter idx, ceil(log2 N) bits (minimum 1 bit).
- IDLE: in_ready=1. On in_valid, latch a, b^{WIDTH{sub}}, and carry register = sub. Clear the sum register and set idx=0. Go to RUN.
- RUN: each cycle, add chunk idx of A and of B' to the carry register in the DIGIT-bit slice. Write the slice result into sum bits [idx*DIGIT +: DIGIT] and its carry-out into the carry register. On the last chunk (idx=N−1), also capture the carry into the MSB bit (the carry out of bit WIDTH−2). Then set cout, compute overflow, and go to DONE. Otherwise idx increments.
- DONE: out_valid=1; sum/cout/overflow stable. On out_ready go to IDLE. in_ready=0, so in_valid is ignored.
- Arithmetic is modulo 2^WIDTH; no saturation. WIDTH=1: the carry into the MSB is the initial carry-in (sub).
- sum/cout/overflow hold their last result in IDLE and RUN. They change only at the final RUN edge; they are never partially visible with out_valid=1.
- Operand inputs are sampled only at the accept edge; later changes have no effect.

## Timing
- Reset: state=IDLE; in_ready=1, out_valid=0, sum=0, cout=0, overflow=0, idx=0, carry=0.
- Reset has priority over all transitions. Asserting rst in RUN or DONE aborts the operation and discards the result. The next cycle shows reset values.
- Accept at edge E (in_valid & in_ready). Chunks are written at edges E+1 … E+N. out_valid is high from edge E+N until the edge where out_ready is sampled high.
- Latency from accept to out_valid is N cycles. With out_ready held high, one operation completes every N+2 cycles (accept, N RUN, DONE).
- out_ready high in the first DONE cycle: out_valid is high for exactly one cycle, and in_ready returns high the following cycle.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- DIGIT=WIDTH: N=1, so the result appears one cycle after accept.

## Test plan
- WIDTH=16, DIGIT=4, a=0xFFFF, b=0x0001, sub=0 → after 4 cycles: sum=0x0000, cout=1, overflow=0.
- a=0x7FFF, b=0x0001, sub=0 → sum=0x8000, cout=0, overflow=1; a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, overflow=1.
- a=0x0005, b=0x0007, sub=1 → sum=0xFFFE, cout=0 (borrow), overflow=0. Change a/b during RUN → result unchanged.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands → out_valid and sum stay stable, in_ready=0, new operands not accepted. Release → exactly one result handshake, then in_ready=1.
- Assert rst at the second RUN cycle → next cycle in_ready=1, out_valid=0, sum=0. A fresh op 0x1234+0x1111 then yields 0x2345.
- Parameter sweep (DIGIT ∈ {1,4,16}, WIDTH=16; WIDTH=8, DIGIT=8), 1000 random ops with random out_ready stalls → sum/cout/overflow match the reference model. Latency equals WIDTH/DIGIT cycles.

Source files
------------

// File: rtl/chunked_serial_adder_if.sv
// Handshake bundle between an operand producer, the chunked serial adder and
// the result consumer. The producer/consumer side uses the master modport,
// the adder itself uses the slave modport.
interface chunked_serial_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;

  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_valid,
    output a,
    output b,
    output sub,
    output out_ready,
    input  in_ready,
    input  sum,
    input  cout,
    input  overflow,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  sub,
    input  out_ready,
    output in_ready,
    output sum,
    output cout,
    output overflow,
    output out_valid
  );

endinterface

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor. A WIDTH-bit operand pair is consumed DIGIT
// bits per clock through a single DIGIT-bit ripple slice, with the carry
// between chunks held in a register. Subtraction is A + ~B + 1: B is
// inverted at accept time and the initial carry is set to one.
// Results (sum, carry-out, signed overflow) are registered and only change
// on the edge that completes the last chunk.
module chunked_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  chunked_serial_adder_if.slave bus
);

  localparam int N    = WIDTH / DIGIT;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  // Refuse to elaborate with a chunk size that does not tile the operand.
  generate
    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("chunked_serial_adder: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             overflow_q;

  logic             accept;
  logic             step;
  logic             last_chunk;
  logic             in_ready_int;
  logic             out_valid_int;

  logic [DIGIT-1:0] a_chunk;
  logic [DIGIT-1:0] b_chunk;
  logic [DIGIT-1:0] slice_sum;
  logic [DIGIT:0]   carry_chain;

  assign last_chunk = (idx == LAST_IDX);

  // State register; reset wins over every transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and handshake outputs for IDLE / RUN / DONE.
  always_comb begin
    state_next    = state;
    in_ready_int  = 1'b0;
    out_valid_int = 1'b0;
    accept        = 1'b0;
    step          = 1'b0;
    case (state)
      IDLE: begin
        in_ready_int = 1'b1;
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last_chunk) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid_int = 1'b1;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // One DIGIT-bit ripple slice fed by the current chunk and the carry register.
  always_comb begin
    a_chunk        = op_a[int'(idx)*DIGIT +: DIGIT];
    b_chunk        = op_b[int'(idx)*DIGIT +: DIGIT];
    carry_chain    = '0;
    carry_chain[0] = carry;
    slice_sum      = '0;
    for (int i = 0; i < DIGIT; i++) begin
      slice_sum[i]     = a_chunk[i] ^ b_chunk[i] ^ carry_chain[i];
      carry_chain[i+1] = (a_chunk[i] & b_chunk[i]) |
                         (carry_chain[i] & (a_chunk[i] ^ b_chunk[i]));
    end
  end

  // Working sum with the current chunk merged in at its bit position.
  always_comb begin
    acc_next = acc;
    acc_next[int'(idx)*DIGIT +: DIGIT] = slice_sum;
  end

  // Operand capture, chunk stepping and result publication. The working
  // accumulator is separate from the visible sum so a result in flight is
  // never partially exposed.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      carry      <= 1'b0;
      acc        <= '0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else if (accept) begin
      op_a  <= bus.a;
      op_b  <= bus.b ^ {WIDTH{bus.sub}};
      carry <= bus.sub;
      acc   <= '0;
      idx   <= '0;
    end else if (step) begin
      acc   <= acc_next;
      carry <= carry_chain[DIGIT];
      if (last_chunk) begin
        sum_q      <= acc_next;
        cout_q     <= carry_chain[DIGIT];
        overflow_q <= carry_chain[DIGIT-1] ^ carry_chain[DIGIT];
        idx        <= '0;
      end else begin
        idx <= idx + IDXW'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_int;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Bench for chunked_serial_adder. Four instances cover WIDTH/DIGIT =
// 16/1, 16/4, 16/16 and 8/8; directed scenarios run on the 16/4 instance and
// a randomized sweep drives all four against an arithmetic reference model.
module tb_chunked_serial_adder;

  localparam int NCFG = 4;
  localparam int M    = 1;
  localparam int MN   = 4;
  localparam int OPS  = 1000;

  function automatic int cfg_w(input int g);
    case (g)
      3:       return 8;
      default: return 16;
    endcase
  endfunction

  function automatic int cfg_d(input int g);
    case (g)
      0:       return 1;
      1:       return 4;
      2:       return 16;
      default: return 8;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [15:0] drv_a        [NCFG];
  logic [15:0] drv_b        [NCFG];
  logic        drv_sub      [NCFG];
  logic        drv_in_valid [NCFG];
  logic        drv_out_ready[NCFG];

  wire  [15:0] obs_sum      [NCFG];
  wire         obs_cout     [NCFG];
  wire         obs_ovf      [NCFG];
  wire         obs_out_valid[NCFG];
  wire         obs_in_ready [NCFG];

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  // Free-running clock.
  always #5 clk = ~clk;

  // One interface + DUT per configuration, bridged to the bench arrays.
  generate
    for (genvar g = 0; g < NCFG; g++) begin : g_dut
      localparam int W = cfg_w(g);
      localparam int D = cfg_d(g);
      chunked_serial_adder_if #(.WIDTH(W)) ifc ();
      chunked_serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
      );
      assign ifc.in_valid     = drv_in_valid[g];
      assign ifc.a            = drv_a[g][W-1:0];
      assign ifc.b            = drv_b[g][W-1:0];
      assign ifc.sub          = drv_sub[g];
      assign ifc.out_ready    = drv_out_ready[g];
      assign obs_sum[g]       = 16'(ifc.sum);
      assign obs_cout[g]      = ifc.cout;
      assign obs_ovf[g]       = ifc.overflow;
      assign obs_out_valid[g] = ifc.out_valid;
      assign obs_in_ready[g]  = ifc.in_ready;
    end
  endgenerate

  // Reference: plain integer arithmetic on w-bit operands.
  function automatic void ref_model(input int w, input logic [15:0] a, input logic [15:0] b,
                                    input logic sub, output logic [15:0] s,
                                    output logic c, output logic v);
    longint modulus, half, ua, ub, sa, sb, r, sr;
    modulus = longint'(1) << w;
    half    = modulus / 2;
    ua      = longint'(a) & (modulus - 1);
    ub      = longint'(b) & (modulus - 1);
    sa      = (ua >= half) ? ua - modulus : ua;
    sb      = (ub >= half) ? ub - modulus : ub;
    r       = sub ? ua - ub : ua + ub;
    sr      = sub ? sa - sb : sa + sb;
    s       = 16'(r & (modulus - 1));
    c       = sub ? (ua >= ub) : (r >= modulus);
    v       = (sr >= half) || (sr < -half);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_stimulus(input int g, input logic [15:0] a, input logic [15:0] b,
                                input logic sub);
    int waited;
    waited = 0;
    while (obs_in_ready[g] !== 1'b1 && waited < 100) begin
      tick();
      waited++;
    end
    if (obs_in_ready[g] !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL accept_timeout cfg%0d: in_ready=%b, expected 1", g, obs_in_ready[g]);
    end
    drv_a[g]        = a;
    drv_b[g]        = b;
    drv_sub[g]      = sub;
    drv_in_valid[g] = 1'b1;
    tick();
    drv_in_valid[g] = 1'b0;
  endtask

  task automatic wait_result(input int g, input bit scribble, output int lat);
    lat = 0;
    while (obs_out_valid[g] !== 1'b1 && lat < 40) begin
      if (scribble) begin
        drv_a[g]   = 16'($urandom);
        drv_b[g]   = 16'($urandom);
        drv_sub[g] = 1'($urandom);
      end
      tick();
      lat++;
    end
    if (obs_out_valid[g] !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL result_timeout cfg%0d: out_valid=%b, expected 1", g, obs_out_valid[g]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    tests_run++; if (obs_in_ready[M] !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %b, expected 1", obs_in_ready[M]); end
    tests_run++; if (obs_out_valid[M] !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %b, expected 0", obs_out_valid[M]); end
    tests_run++; if (obs_sum[M] !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_sum: got %h, expected 0000", obs_sum[M]); end
    tests_run++; if (obs_cout[M] !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_cout: got %b, expected 0", obs_cout[M]); end
    tests_run++; if (obs_ovf[M] !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_overflow: got %b, expected 0", obs_ovf[M]); end
  endtask

  task automatic test_directed();
    logic [15:0] va[5], vb[5], es[5];
    logic        vs[5], ec[5], eo[5];
    int          lat;
    va[0] = 16'hFFFF; vb[0] = 16'h0001; vs[0] = 1'b0; es[0] = 16'h0000; ec[0] = 1'b1; eo[0] = 1'b0;
    va[1] = 16'h7FFF; vb[1] = 16'h0001; vs[1] = 1'b0; es[1] = 16'h8000; ec[1] = 1'b0; eo[1] = 1'b1;
    va[2] = 16'h8000; vb[2] = 16'h0001; vs[2] = 1'b1; es[2] = 16'h7FFF; ec[2] = 1'b1; eo[2] = 1'b1;
    va[3] = 16'h0005; vb[3] = 16'h0007; vs[3] = 1'b1; es[3] = 16'hFFFE; ec[3] = 1'b0; eo[3] = 1'b0;
    va[4] = 16'h1234; vb[4] = 16'h1111; vs[4] = 1'b0; es[4] = 16'h2345; ec[4] = 1'b0; eo[4] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(M, va[i], vb[i], vs[i]);
      wait_result(M, 1'b1, lat);
      tests_run++; if (lat != MN) begin tests_failed++; $display("[TB] FAIL directed%0d_latency: got %0d, expected %0d", i, lat, MN); end
      tests_run++; if (obs_sum[M] !== es[i]) begin tests_failed++; $display("[TB] FAIL directed%0d_sum: got %h, expected %h", i, obs_sum[M], es[i]); end
      tests_run++; if (obs_cout[M] !== ec[i]) begin tests_failed++; $display("[TB] FAIL directed%0d_cout: got %b, expected %b", i, obs_cout[M], ec[i]); end
      tests_run++; if (obs_ovf[M] !== eo[i]) begin tests_failed++; $display("[TB] FAIL directed%0d_overflow: got %b, expected %b", i, obs_ovf[M], eo[i]); end
      drv_out_ready[M] = 1'b1;
      tick();
      drv_out_ready[M] = 1'b0;
      tests_run++; if (obs_out_valid[M] !== 1'b0) begin tests_failed++; $display("[TB] FAIL directed%0d_release: out_valid=%b, expected 0", i, obs_out_valid[M]); end
      tests_run++; if (obs_in_ready[M] !== 1'b1) begin tests_failed++; $display("[TB] FAIL directed%0d_idle: in_ready=%b, expected 1", i, obs_in_ready[M]); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit seen;
    apply_stimulus(M, 16'h0123, 16'h4567, 1'b0);
    wait_result(M, 1'b0, lat);
    for (int k = 0; k < 5; k++) begin
      drv_in_valid[M] = (k % 2 == 0);
      drv_a[M]        = 16'($urandom);
      drv_b[M]        = 16'($urandom);
      tick();
      tests_run++; if (obs_out_valid[M] !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall%0d_out_valid: got %b, expected 1", k, obs_out_valid[M]); end
      tests_run++; if (obs_in_ready[M] !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall%0d_in_ready: got %b, expected 0", k, obs_in_ready[M]); end
      tests_run++; if (obs_sum[M] !== 16'h468A) begin tests_failed++; $display("[TB] FAIL stall%0d_sum: got %h, expected 468a", k, obs_sum[M]); end
    end
    drv_in_valid[M]  = 1'b0;
    drv_out_ready[M] = 1'b1;
    tick();
    drv_out_ready[M] = 1'b0;
    tests_run++; if (obs_out_valid[M] !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_release: out_valid=%b, expected 0", obs_out_valid[M]); end
    tests_run++; if (obs_in_ready[M] !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall_idle: in_ready=%b, expected 1", obs_in_ready[M]); end
    seen = 1'b0;
    for (int k = 0; k < MN + 2; k++) begin
      tick();
      if (obs_out_valid[M] === 1'b1 || obs_in_ready[M] !== 1'b1) seen = 1'b1;
    end
    tests_run++; if (seen) begin tests_failed++; $display("[TB] FAIL stall_no_extra_op: activity=1, expected 0"); end
  endtask

  task automatic test_reset_abort();
    int lat;
    bit seen;
    apply_stimulus(M, 16'hAAAA, 16'h5555, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++; if (obs_in_ready[M] !== 1'b1) begin tests_failed++; $display("[TB] FAIL abort_in_ready: got %b, expected 1", obs_in_ready[M]); end
    tests_run++; if (obs_out_valid[M] !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_out_valid: got %b, expected 0", obs_out_valid[M]); end
    tests_run++; if (obs_sum[M] !== 16'h0000) begin tests_failed++; $display("[TB] FAIL abort_sum: got %h, expected 0000", obs_sum[M]); end
    seen = 1'b0;
    for (int k = 0; k < MN + 2; k++) begin
      tick();
      if (obs_out_valid[M] === 1'b1) seen = 1'b1;
    end
    tests_run++; if (seen) begin tests_failed++; $display("[TB] FAIL abort_discard: out_valid seen=1, expected 0"); end
    apply_stimulus(M, 16'h1234, 16'h1111, 1'b0);
    wait_result(M, 1'b0, lat);
    tests_run++; if (obs_sum[M] !== 16'h2345) begin tests_failed++; $display("[TB] FAIL abort_fresh_sum: got %h, expected 2345", obs_sum[M]); end
    tests_run++; if (lat != MN) begin tests_failed++; $display("[TB] FAIL abort_fresh_latency: got %0d, expected %0d", lat, MN); end
    drv_out_ready[M] = 1'b1;
    tick();
    drv_out_ready[M] = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] q_s[$];
    logic        q_c[$], q_v[$];
    logic [15:0] es;
    logic        ec, ev;
    int          accepted, done, last_accept, cycles;
    accepted    = 0;
    done        = 0;
    last_accept = -1;
    cycles      = 0;
    drv_out_ready[M] = 1'b1;
    while (done < 4 && cycles < 200) begin
      drv_in_valid[M] = (accepted < 4);
      drv_a[M]        = 16'($urandom);
      drv_b[M]        = 16'($urandom);
      drv_sub[M]      = 1'($urandom);
      if (obs_out_valid[M] === 1'b1 && q_s.size() > 0) begin
        es = q_s.pop_front(); ec = q_c.pop_front(); ev = q_v.pop_front();
        tests_run++; if (obs_sum[M] !== es || obs_cout[M] !== ec || obs_ovf[M] !== ev) begin
          tests_failed++;
          $display("[TB] FAIL b2b%0d_result: got %h/%b/%b, expected %h/%b/%b", done, obs_sum[M], obs_cout[M], obs_ovf[M], es, ec, ev);
        end
        done++;
      end
      if (obs_in_ready[M] === 1'b1 && drv_in_valid[M]) begin
        ref_model(16, drv_a[M], drv_b[M], drv_sub[M], es, ec, ev);
        q_s.push_back(es); q_c.push_back(ec); q_v.push_back(ev);
        if (last_accept >= 0) begin
          tests_run++; if (cyc + 1 - last_accept != MN + 2) begin tests_failed++; $display("[TB] FAIL b2b%0d_spacing: got %0d, expected %0d", accepted, cyc + 1 - last_accept, MN + 2); end
        end
        last_accept = cyc + 1;
        accepted++;
      end
      tick();
      cycles++;
    end
    drv_in_valid[M]  = 1'b0;
    drv_out_ready[M] = 1'b0;
    tests_run++; if (done != 4) begin tests_failed++; $display("[TB] FAIL b2b_count: got %0d, expected 4", done); end
    tick();
  endtask

  task automatic test_sweep();
    int          done_ops[NCFG], accept_edge[NCFG];
    bit          pending[NCFG], seen_valid[NCFG];
    logic [15:0] es[NCFG];
    logic        ec[NCFG], ev[NCFG];
    int          cycles;
    bit          busy;
    for (int g = 0; g < NCFG; g++) begin
      done_ops[g] = 0; accept_edge[g] = 0; pending[g] = 1'b0; seen_valid[g] = 1'b0;
    end
    cycles = 0;
    busy   = 1'b1;
    while (busy && cycles < 60000) begin
      busy = 1'b0;
      for (int g = 0; g < NCFG; g++) begin
        if (done_ops[g] < OPS) busy = 1'b1;
        drv_out_ready[g] = ($urandom_range(0, 3) != 0);
        drv_in_valid[g]  = !pending[g] && (done_ops[g] < OPS) && ($urandom_range(0, 3) != 0);
        drv_a[g]         = 16'($urandom);
        drv_b[g]         = 16'($urandom);
        drv_sub[g]       = 1'($urandom);
        if (obs_out_valid[g] === 1'b1) begin
          if (!pending[g]) begin
            tests_run++; tests_failed++;
            $display("[TB] FAIL sweep_cfg%0d_spurious: out_valid=1, expected 0", g);
          end else begin
            if (!seen_valid[g]) begin
              seen_valid[g] = 1'b1;
              tests_run++; if (cyc - accept_edge[g] != cfg_w(g) / cfg_d(g)) begin tests_failed++; $display("[TB] FAIL sweep_cfg%0d_latency: got %0d, expected %0d", g, cyc - accept_edge[g], cfg_w(g) / cfg_d(g)); end
            end
            if (drv_out_ready[g]) begin
              tests_run++; if (obs_sum[g] !== es[g]) begin tests_failed++; $display("[TB] FAIL sweep_cfg%0d_sum: got %h, expected %h", g, obs_sum[g], es[g]); end
              tests_run++; if (obs_cout[g] !== ec[g]) begin tests_failed++; $display("[TB] FAIL sweep_cfg%0d_cout: got %b, expected %b", g, obs_cout[g], ec[g]); end
              tests_run++; if (obs_ovf[g] !== ev[g]) begin tests_failed++; $display("[TB] FAIL sweep_cfg%0d_overflow: got %b, expected %b", g, obs_ovf[g], ev[g]); end
              done_ops[g]++;
              pending[g]    = 1'b0;
              seen_valid[g] = 1'b0;
            end
          end
        end
        if (obs_in_ready[g] === 1'b1 && drv_in_valid[g]) begin
          ref_model(cfg_w(g), drv_a[g], drv_b[g], drv_sub[g], es[g], ec[g], ev[g]);
          accept_edge[g] = cyc + 1;
          pending[g]     = 1'b1;
        end
      end
      tick();
      cycles++;
    end
    for (int g = 0; g < NCFG; g++) begin
      drv_in_valid[g]  = 1'b0;
      drv_out_ready[g] = 1'b0;
      tests_run++; if (done_ops[g] != OPS) begin tests_failed++; $display("[TB] FAIL sweep_cfg%0d_count: got %0d, expected %0d", g, done_ops[g], OPS); end
    end
  endtask

  // Scenario sequence.
  initial begin
    for (int g = 0; g < NCFG; g++) begin
      drv_a[g] = '0; drv_b[g] = '0; drv_sub[g] = 1'b0;
      drv_in_valid[g] = 1'b0; drv_out_ready[g] = 1'b0;
    end
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
